// File: rtl/lmem_pkg.sv
// Shared constants and request payload type for the layer-memory port arbiter.
package lmem_pkg;
    localparam int unsigned AW_DEF = 12;
    localparam int unsigned DW_DEF = 20;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] CSEL_L0_K0 = 3'b001;
    localparam logic [SEL_W-1:0] CSEL_L0_K1 = 3'b010;
    localparam logic [SEL_W-1:0] CSEL_L1_K0 = 3'b011;

    typedef struct packed {
        logic              we;
        logic              lock;
        logic [SEL_W-1:0]  sel;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } lmem_req_t;
endpackage

// File: rtl/lmem_arbiter_if.sv
// Requester-side and memory-side signal bundle of the layer-memory arbiter.
interface lmem_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = lmem_pkg::AW_DEF,
    parameter int unsigned DW   = lmem_pkg::DW_DEF
);
    import lmem_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_we;
    logic [NREQ-1:0]       req_lock;
    logic [SEL_W*NREQ-1:0] req_sel;
    logic [AW*NREQ-1:0]    req_addr;
    logic [DW*NREQ-1:0]    req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic [SEL_W-1:0]      csel;
    logic                  crd;
    logic [AW-1:0]         caddr_rd;
    logic [DW-1:0]         cdata_rd;
    logic                  cwr;
    logic [AW-1:0]         caddr_wr;
    logic [DW-1:0]         cdata_wr;

    modport slave (
        input  req_valid, req_we, req_lock, req_sel, req_addr, req_wdata, cdata_rd,
        output req_ready, rsp_valid, rsp_data, csel, crd, caddr_rd, cwr, caddr_wr, cdata_wr
    );

    modport master (
        output req_valid, req_we, req_lock, req_sel, req_addr, req_wdata, cdata_rd,
        input  req_ready, rsp_valid, rsp_data, csel, crd, caddr_rd, cwr, caddr_wr, cdata_wr
    );
endinterface

// File: rtl/lmem_rr_pick.sv
// Rotating-priority picker: first requester after rr_ptr (wrapping) wins.
module lmem_rr_pick #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);
    // Walk farthest-first so the nearest requester after rr_ptr overwrites last.
    always_comb begin
        int unsigned cand;
        grant = '0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (32'(rr_ptr) + k) % NREQ;
            if (req[cand]) begin
                grant = NREQ'(1) << cand;
                idx   = IW'(cand);
            end
        end
    end
endmodule

// File: rtl/lmem_arbiter.sv
// Round-robin arbiter sharing one layer-memory port; LMEM_ARB_LOCK_EN enables
// requester-held locks for atomic bursts.
module lmem_arbiter
    import lmem_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input logic           clk,
    input logic           reset,
    lmem_arbiter_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]    rr_ptr;
    logic [NREQ-1:0]  pick_req;
    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    gidx;
    logic             accept;
    logic             beat_we;
    logic [SEL_W-1:0] beat_sel;
    logic [AW-1:0]    beat_addr;
    logic [DW-1:0]    beat_wdata;
    logic [NREQ-1:0]  tag_pipe [RD_LAT+1];

`ifdef LMEM_ARB_LOCK_EN
    logic          locked;
    logic [IW-1:0] owner;
    logic          beat_lock;

    // While locked, only the owner is presented to the picker.
    always_comb begin
        pick_req = bus.req_valid;
        if (locked) pick_req = bus.req_valid & (NREQ'(1) << owner);
    end

    assign beat_lock = bus.req_lock[gidx];

    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
            owner  <= '0;
        end else if (accept) begin
            locked <= beat_lock;
            if (beat_lock) owner <= gidx;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
    assign pick_req    = bus.req_valid;
`endif

    lmem_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (pick_req),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (gidx)
    );

    // Grant is withheld during reset so no beat is handed out and then dropped.
    assign bus.req_ready = reset ? '0 : grant;
    assign accept        = ~reset & (|grant);

    always_comb begin
        beat_we    = bus.req_we[gidx];
        beat_sel   = bus.req_sel[32'(gidx)*SEL_W +: SEL_W];
        beat_addr  = bus.req_addr[32'(gidx)*AW +: AW];
        beat_wdata = bus.req_wdata[32'(gidx)*DW +: DW];
    end

    // Memory-side registers; select and addresses hold across idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= IW'(NREQ-1);
            bus.crd      <= 1'b0;
            bus.cwr      <= 1'b0;
            bus.csel     <= '0;
            bus.caddr_rd <= '0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
        end else begin
            bus.crd <= accept & ~beat_we;
            bus.cwr <= accept & beat_we;
            if (accept) begin
                rr_ptr   <= gidx;
                bus.csel <= beat_sel;
                if (beat_we) begin
                    bus.caddr_wr <= beat_addr;
                    bus.cdata_wr <= beat_wdata;
                end else begin
                    bus.caddr_rd <= beat_addr;
                end
            end
        end
    end

    // Stage 0 lines up with crd; stage RD_LAT lines up with cdata_rd.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s <= RD_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            tag_pipe[0] <= (accept & ~beat_we) ? grant : '0;
            for (int unsigned s = 1; s <= RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    assign bus.rsp_valid = tag_pipe[RD_LAT];
    assign bus.rsp_data  = bus.cdata_rd;
endmodule

// File: tb/tb_lmem_arbiter.sv
// Directed bench for lmem_arbiter: vector table plus lock and reset sequences.
module tb_lmem_arbiter;
    import lmem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    lmem_arbiter_if #(.NREQ(3), .AW(12), .DW(20)) b1 ();
    lmem_arbiter_if #(.NREQ(3), .AW(12), .DW(20)) b2 ();

    lmem_arbiter #(.NREQ(3), .AW(12), .DW(20), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .bus(b1));
    lmem_arbiter #(.NREQ(3), .AW(12), .DW(20), .RD_LAT(2)) dut2 (
        .clk(clk), .reset(reset2), .bus(b2));

    logic [2:0]  d_valid, d_we, d_lock;
    logic [8:0]  d_sel;
    logic [35:0] d_addr;
    logic [59:0] d_wdata;
    logic [2:0]  e_valid;
    logic [19:0] rdata;
    logic [19:0] mem [4096];

    assign b1.req_valid = d_valid;
    assign b1.req_we    = d_we;
    assign b1.req_lock  = d_lock;
    assign b1.req_sel   = d_sel;
    assign b1.req_addr  = d_addr;
    assign b1.req_wdata = d_wdata;
    assign b1.cdata_rd  = rdata;

    assign b2.req_valid = e_valid;
    assign b2.req_we    = '0;
    assign b2.req_lock  = '0;
    assign b2.req_sel   = '0;
    assign b2.req_addr  = '0;
    assign b2.req_wdata = '0;
    assign b2.cdata_rd  = '0;

    // Single-port memory with one cycle of read latency, preloaded with D0000|addr.
    always @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
            for (int a = 0; a < 4096; a++) mem[a] <= 20'hD0000 | 20'(a);
        end else begin
            if (b1.cwr) mem[b1.caddr_wr] <= b1.cdata_wr;
            if (b1.crd) rdata <= mem[b1.caddr_rd];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  v, we;
        logic [11:0] ab;
        logic [19:0] wb;
        logic [2:0]  e_ready;
        logic        e_crd, e_cwr;
        logic [2:0]  e_csel;
        logic [11:0] e_addr;
        logic [19:0] e_wdata;
        logic [2:0]  e_rsp;
        logic [19:0] e_rdata;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic [2:0] v, we, input logic [11:0] ab,
                                input logic [19:0] wb, input logic [2:0] rdy,
                                input logic crd, cwr, input logic [2:0] csel,
                                input logic [11:0] addr, input logic [19:0] wd,
                                input logic [2:0] rsp, input logic [19:0] rd);
        vec_t t;
        t.v = v; t.we = we; t.ab = ab; t.wb = wb; t.e_ready = rdy;
        t.e_crd = crd; t.e_cwr = cwr; t.e_csel = csel; t.e_addr = addr;
        t.e_wdata = wd; t.e_rsp = rsp; t.e_rdata = rd;
        return t;
    endfunction

    function automatic logic [2:0] sel_of(input int i);
        case (i)
            0:       return CSEL_L0_K0;
            1:       return CSEL_L0_K1;
            default: return CSEL_L1_K0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Requester i gets addr ab+i and wdata wb+i so a wrong mux index is visible.
    task automatic set_req(input logic [2:0] v, we, lk, input logic [11:0] ab,
                           input logic [19:0] wb);
        lmem_req_t r;
        d_valid = v;
        for (int i = 0; i < 3; i++) begin
            r.we = we[i]; r.lock = lk[i]; r.sel = sel_of(i);
            r.addr = ab + 12'(i); r.wdata = wb + 20'(i);
            d_we[i] = r.we;
            d_lock[i] = r.lock;
            d_sel[i*3 +: 3] = r.sel;
            d_addr[i*12 +: 12] = r.addr;
            d_wdata[i*20 +: 20] = r.wdata;
        end
    endtask

    task automatic hstep(input string nm, input logic [2:0] v, we, lk,
                         input logic [2:0] exp_ready, input logic exp_crd, exp_cwr);
        @(posedge clk); #1;
        chk({nm, ".crd"}, 32'(b1.crd), 32'(exp_crd));
        chk({nm, ".cwr"}, 32'(b1.cwr), 32'(exp_cwr));
        set_req(v, we, lk, 12'h200, 20'h0);
        #1;
        chk({nm, ".ready"}, 32'(b1.req_ready), 32'(exp_ready));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] hv [7], hwe [7], hlk [7], hexp [7], hcrd [7], hcwr [7];
        logic [2:0] dv [5], dlk [5], dexp [5], dcrd [5];

        reset = 1'b1; reset2 = 1'b1;
        set_req(3'b111, 3'b000, 3'b000, 12'h100, 20'h0);
        e_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready",    32'(b1.req_ready), 32'(0));
        chk("rst.crd",      32'(b1.crd),       32'(0));
        chk("rst.cwr",      32'(b1.cwr),       32'(0));
        chk("rst.csel",     32'(b1.csel),      32'(0));
        chk("rst.caddr_rd", 32'(b1.caddr_rd),  32'(0));
        chk("rst.caddr_wr", 32'(b1.caddr_wr),  32'(0));
        chk("rst.cdata_wr", 32'(b1.cdata_wr),  32'(0));
        chk("rst.rsp",      32'(b1.rsp_valid), 32'(0));
        chk("rst2.ready",   32'(b2.req_ready), 32'(0));
        chk("rst2.rsp",     32'(b2.rsp_valid), 32'(0));
        set_req(3'b000, 3'b000, 3'b000, 12'h100, 20'h0);
        e_valid = 3'b000;
        reset = 1'b0; reset2 = 1'b0;

        //            v       we      ab      wb        rdy     crd   cwr   csel    addr    wdata     rsp     rdata
        tbl[0]  = mk(3'b111, 3'b000, 12'h100, 20'h0,    3'b001, 1'b0, 1'b0, 3'b000, 12'h0,   20'h0,    3'b000, 20'h0);
        tbl[1]  = mk(3'b111, 3'b000, 12'h100, 20'h0,    3'b010, 1'b1, 1'b0, 3'b001, 12'h100, 20'h0,    3'b000, 20'h0);
        tbl[2]  = mk(3'b111, 3'b000, 12'h100, 20'h0,    3'b100, 1'b1, 1'b0, 3'b010, 12'h101, 20'h0,    3'b001, 20'hD0100);
        tbl[3]  = mk(3'b111, 3'b000, 12'h100, 20'h0,    3'b001, 1'b1, 1'b0, 3'b011, 12'h102, 20'h0,    3'b010, 20'hD0101);
        tbl[4]  = mk(3'b111, 3'b000, 12'h100, 20'h0,    3'b010, 1'b1, 1'b0, 3'b001, 12'h100, 20'h0,    3'b100, 20'hD0102);
        tbl[5]  = mk(3'b111, 3'b000, 12'h100, 20'h0,    3'b100, 1'b1, 1'b0, 3'b010, 12'h101, 20'h0,    3'b001, 20'hD0100);
        tbl[6]  = mk(3'b000, 3'b000, 12'h100, 20'h0,    3'b000, 1'b1, 1'b0, 3'b011, 12'h102, 20'h0,    3'b010, 20'hD0101);
        tbl[7]  = mk(3'b000, 3'b000, 12'h100, 20'h0,    3'b000, 1'b0, 1'b0, 3'b011, 12'h0,   20'h0,    3'b100, 20'hD0102);
        tbl[8]  = mk(3'b000, 3'b000, 12'h100, 20'h0,    3'b000, 1'b0, 1'b0, 3'b011, 12'h0,   20'h0,    3'b000, 20'h0);
        tbl[9]  = mk(3'b001, 3'b001, 12'h041, 20'h00123, 3'b001, 1'b0, 1'b0, 3'b011, 12'h0,   20'h0,    3'b000, 20'h0);
        tbl[10] = mk(3'b010, 3'b000, 12'h040, 20'h0,    3'b010, 1'b0, 1'b1, 3'b001, 12'h041, 20'h00123, 3'b000, 20'h0);
        tbl[11] = mk(3'b000, 3'b000, 12'h040, 20'h0,    3'b000, 1'b1, 1'b0, 3'b010, 12'h041, 20'h0,    3'b000, 20'h0);
        tbl[12] = mk(3'b000, 3'b000, 12'h040, 20'h0,    3'b000, 1'b0, 1'b0, 3'b010, 12'h0,   20'h0,    3'b010, 20'h00123);

        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d.crd", k),  32'(b1.crd),       32'(tbl[k].e_crd));
            chk($sformatf("v%0d.cwr", k),  32'(b1.cwr),       32'(tbl[k].e_cwr));
            chk($sformatf("v%0d.csel", k), 32'(b1.csel),      32'(tbl[k].e_csel));
            chk($sformatf("v%0d.rsp", k),  32'(b1.rsp_valid), 32'(tbl[k].e_rsp));
            if (tbl[k].e_crd)
                chk($sformatf("v%0d.caddr_rd", k), 32'(b1.caddr_rd), 32'(tbl[k].e_addr));
            if (tbl[k].e_cwr) begin
                chk($sformatf("v%0d.caddr_wr", k), 32'(b1.caddr_wr), 32'(tbl[k].e_addr));
                chk($sformatf("v%0d.cdata_wr", k), 32'(b1.cdata_wr), 32'(tbl[k].e_wdata));
            end
            if (tbl[k].e_rsp != 3'b000)
                chk($sformatf("v%0d.rsp_data", k), 32'(b1.rsp_data), 32'(tbl[k].e_rdata));
            set_req(tbl[k].v, tbl[k].we, 3'b000, tbl[k].ab, tbl[k].wb);
            #1;
            chk($sformatf("v%0d.ready", k), 32'(b1.req_ready), 32'(tbl[k].e_ready));
        end

        // Burst by requester 1 (four locked reads, unlocking write) against contention.
        hv  = '{3'b001, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        hwe = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        hlk = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
`ifdef LMEM_ARB_LOCK_EN
        hexp = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
        hcrd = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        hcwr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
`else
        hexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        hcrd = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        hcwr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
        for (int k = 0; k < 7; k++)
            hstep($sformatf("burst%0d", k), hv[k], hwe[k], hlk[k], hexp[k], hcrd[k][0], hcwr[k][0]);

        // Lock owner goes quiet for two cycles, then returns with an unlocking beat.
        dv  = '{3'b010, 3'b101, 3'b101, 3'b111, 3'b111};
        dlk = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
`ifdef LMEM_ARB_LOCK_EN
        dexp = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b100};
        dcrd = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
`else
        dexp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        dcrd = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
`endif
        for (int k = 0; k < 5; k++)
            hstep($sformatf("drop%0d", k), dv[k], 3'b000, dlk[k], dexp[k], dcrd[k][0], 1'b0);

        // RD_LAT=2 instance: two reads in flight when reset hits.
        @(posedge clk); #1;
        set_req(3'b000, 3'b000, 3'b000, 12'h0, 20'h0);
        e_valid = 3'b111;
        #1; chk("mid.ready_a", 32'(b2.req_ready), 32'(3'b001));
        @(posedge clk); #1;
        #1; chk("mid.ready_b", 32'(b2.req_ready), 32'(3'b010));
        @(posedge clk); #1;
        chk("mid.crd_inflight", 32'(b2.crd), 32'(1));
        chk("mid.rsp_early",    32'(b2.rsp_valid), 32'(0));
        e_valid = 3'b000;
        reset2 = 1'b1;
        #1; chk("mid.ready_rst", 32'(b2.req_ready), 32'(0));
        @(posedge clk); #1;
        reset2 = 1'b0;
        chk("mid.crd_after_rst", 32'(b2.crd), 32'(0));
        chk("mid.csel_after_rst", 32'(b2.csel), 32'(0));
        chk("mid.rsp_after_rst", 32'(b2.rsp_valid), 32'(0));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid.rsp_quiet%0d", k), 32'(b2.rsp_valid), 32'(0));
        end
        e_valid = 3'b111;
        #1; chk("mid.ready_first", 32'(b2.req_ready), 32'(3'b001));
        @(posedge clk); #1;
        e_valid = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lmem_arbiter.md
# lmem_arbiter

Shares the single layer-memory port (csel/crd/caddr_rd/cdata_rd/cwr/caddr_wr/cdata_wr) among several engines: the convolution writer, the max-pool reader/writer and a readback/debug requester. Each accepted beat is one read or one write. Arbitration is round-robin, and a requester can optionally lock the port for an atomic burst, such as a 4-read + 1-write max-pool window. Read data returns on a shared bus, tagged to the issuing requester by a one-hot valid.

## Interface
- NREQ, 3: number of requesters, 2..4.
- AW, 12: layer-memory address width.
- DW, 20: data width.
- RD_LAT, 1: cycles from a cycle with crd=1 to valid cdata_rd, 1..4.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  beat request per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_lock  in  NREQ  keep the grant after this beat (honoured only with LMEM_ARB_LOCK_EN).
- req_sel  in  3*NREQ  memory select per requester.
- req_addr  in  AW*NREQ  address per requester.
- req_wdata  in  DW*NREQ  write data per requester.
- req_ready  out  NREQ  one-hot grant; a beat is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  one-hot read-return strobe.
- rsp_data  out  DW  read data; equals cdata_rd.
- csel  out  3  registered memory select.
- crd  out  1  registered read strobe.
- caddr_rd  out  AW  registered read address.
- cdata_rd  in  DW  memory read data.
- cwr  out  1  registered write strobe.
- caddr_wr  out  AW  registered write address.
- cdata_wr  out  DW  registered write data.

## Operation
- Reset values:
  - req_ready, rsp_valid, csel, crd, cwr, caddr_rd, caddr_wr, cdata_wr all 0.
  - rr_ptr = NREQ-1, so requester 0 wins first.
  - Lock cleared; read-tag pipeline flushed.
- Unlocked arbitration:
  - Search begins at rr_ptr+1 mod NREQ; the first requester with req_valid set gets req_ready.
  - req_ready is combinational from req_valid, rr_ptr and lock state only. It never depends on req_we, addr or data.
  - On acceptance, rr_ptr takes the granted index.
- Accepted write: next cycle cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
- Accepted read: next cycle crd=1, caddr_rd=addr, csel=sel, cwr=0.
- Idle cycle (nothing accepted): crd=0 and cwr=0. csel and all address/data registers hold their last values.
- crd and cwr are never both 1.
- Read tags: a one-hot requester tag is shifted through an RD_LAT-deep pipeline. rsp_valid is the pipeline output, aligned to valid cdata_rd. rsp_data is a passthrough of cdata_rd.
- Locking (macro enabled):
  - Accepting a beat with req_lock=1 sets the lock to that owner.
  - While locked, only the owner can be granted. If the owner drops req_valid, the port idles and other requesters stall.
  - An owner beat accepted with req_lock=0 releases the lock. rr_ptr updates normally.
- Reset mid-burst: lock dropped, in-flight read tags discarded, no rsp_valid afterwards.

## Timing
- Throughput: one beat per cycle, back-to-back beats and read/write mixing allowed.
- Accept at edge t means memory outputs are valid in cycle t+1.
- rsp_valid for a read accepted at edge t is high in cycle t+1+RD_LAT, for exactly one cycle.
- Write-then-read to the same address in consecutive beats is ordered by issue. The memory sees the write at t+1 and the read at t+2.
- Only the granted requester's accept moves rr_ptr. Requesters not asking are skipped with no lost cycle.
- Reset asserted in cycle t forces every output to 0 at edge t+1, regardless of state.

## Configuration
- LMEM_ARB_LOCK_EN defined: req_lock honoured as described in Operation.
- LMEM_ARB_LOCK_EN undefined:
  - req_lock is ignored and lock logic is not built.
  - Arbitration is strict per-beat round-robin.
  - The port list is unchanged.

## Structure
- Package lmem_pkg:
  - csel encodings CSEL_L0_K0=3'b001, CSEL_L0_K1=3'b010, CSEL_L1_K0=3'b011.
  - AW/DW defaults.
  - Packed request struct {we, lock, sel, addr, wdata}.
- Sub-module lmem_rr_pick: combinational rotating-priority picker.
  - Inputs: NREQ request vector, rr_ptr.
  - Outputs: one-hot grant, encoded index.
- The top level holds rr_ptr, lock state, output registers and the tag pipeline.

## Test plan
- Reset, then req_valid=3'b111 all reads, held for 6 cycles: grants go 0,1,2,0,1,2. With RD_LAT=1, rsp_valid follows 2 cycles after each accept with matching index.
- Req 0 writes addr 12'h041, data 20'h00123; req 1 reads 12'h041 in the next cycle: memory sees cwr then crd. rsp_valid[1] carries 20'h00123.
- Macro on: req 1 runs a 5-beat burst (4 reads with lock=1, then a write with lock=0) while reqs 0 and 2 are valid: all 5 beats are consecutive grants to 1. The next grant is 2.
- Macro on: lock owner drops valid for 2 cycles: crd=cwr=0 in those cycles, and others keep req_ready=0.
- Macro off, same stimulus as the lock test: grants interleave 1,2,0,1,…
- Reset asserted while 2 reads are in flight (RD_LAT=2): no rsp_valid ever asserted. Next grant goes to requester 0.
